// File: rtl/rvb_arbiter.sv
// Two-requester front-end for a shared combinational bitmanip unit. It grants at most one
// request per cycle and holds each requester's result in a one-entry response buffer.
module rvb_arbiter #(
   parameter int XLEN       = 64,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [XLEN-1:0] req0_rs1,
   input  logic [XLEN-1:0] req0_rs2,
   input  logic [XLEN-1:0] req0_rs3,
   input  logic [8:0]      req0_insn,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req1_rs1,
   input  logic [XLEN-1:0] req1_rs2,
   input  logic [XLEN-1:0] req1_rs3,
   input  logic [8:0]      req1_insn,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [XLEN-1:0] rsp0_rd,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp1_rd,
   output logic            unit_valid,
   output logic [XLEN-1:0] unit_rs1,
   output logic [XLEN-1:0] unit_rs2,
   output logic [XLEN-1:0] unit_rs3,
   output logic [8:0]      unit_insn,
   input  logic [XLEN-1:0] unit_rd
);

   logic            full0_q, full0_d;
   logic            full1_q, full1_d;
   logic [XLEN-1:0] rd0_q, rd0_d;
   logic [XLEN-1:0] rd1_q, rd1_d;
   logic            prio_q, prio_d;
   logic            elig0, elig1;
   logic            grant0, grant1;

   // A full buffer whose consumer takes the result this cycle can be refilled at once.
   always_comb begin
      elig0  = req0_valid && (!full0_q || rsp0_ready);
      elig1  = req1_valid && (!full1_q || rsp1_ready);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (elig0 && elig1) begin
         if (FIXED_PRIO || !prio_q) grant0 = 1'b1;
         else                       grant1 = 1'b1;
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
   end

   always_comb begin
      unit_valid = grant0 || grant1;
      unit_rs1   = '0;
      unit_rs2   = '0;
      unit_rs3   = '0;
      unit_insn  = '0;
      if (grant0) begin
         unit_rs1  = req0_rs1;
         unit_rs2  = req0_rs2;
         unit_rs3  = req0_rs3;
         unit_insn = req0_insn;
      end else if (grant1) begin
         unit_rs1  = req1_rs1;
         unit_rs2  = req1_rs2;
         unit_rs3  = req1_rs3;
         unit_insn = req1_insn;
      end
   end

   always_comb begin
      full0_d = full0_q;
      full1_d = full1_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      prio_d  = prio_q;
      if (grant0) begin
         full0_d = 1'b1;
         rd0_d   = unit_rd;
      end else if (rsp0_ready) begin
         full0_d = 1'b0;
      end
      if (grant1) begin
         full1_d = 1'b1;
         rd1_d   = unit_rd;
      end else if (rsp1_ready) begin
         full1_d = 1'b0;
      end
      if (grant0)      prio_d = 1'b1;
      else if (grant1) prio_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full0_q <= 1'b0;
         full1_q <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         prio_q  <= 1'b0;
      end else begin
         full0_q <= full0_d;
         full1_q <= full1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         prio_q  <= prio_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = full0_q;
   assign rsp1_valid = full1_q;
   assign rsp0_rd    = rd0_q;
   assign rsp1_rd    = rd1_q;

endmodule

// File: tb/tb_rvb_arbiter.sv
// Bench for rvb_arbiter: a round-robin and a fixed-priority instance share stimulus; a small
// unit model closes the loop and per-requester scoreboards hold expected results.
module tb_rvb_arbiter;
   localparam int XLEN = 64;
   localparam logic [8:0] I_MIN  = 9'b010110010;
   localparam logic [8:0] I_ANDN = 9'b100011110;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      req_valid;
   logic [1:0]      rsp_ready;
   logic [XLEN-1:0] rs1 [2];
   logic [XLEN-1:0] rs2 [2];
   logic [XLEN-1:0] rs3 [2];
   logic [8:0]      insn [2];

   logic [1:0]      req_ready_a, rsp_valid_a, req_ready_f, rsp_valid_f;
   logic [XLEN-1:0] rsp_rd_a [2];
   logic [XLEN-1:0] rsp_rd_f [2];
   logic            unit_valid_a, unit_valid_f;
   logic [XLEN-1:0] u_rs1_a, u_rs2_a, u_rs3_a, u_rd_a;
   logic [XLEN-1:0] u_rs1_f, u_rs2_f, u_rs3_f, u_rd_f;
   logic [8:0]      u_insn_a, u_insn_f;

   logic [XLEN-1:0] sb0 [$];
   logic [XLEN-1:0] sb1 [$];
   logic [XLEN-1:0] sbf0 [$];
   logic [XLEN-1:0] exp_v;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in for the shared bitmanip unit: MIN and ANDN exact, everything else a mixing function.
   function automatic logic [XLEN-1:0] unit_model(input logic [8:0] i, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
      case (i)
         I_MIN:   return ($signed(a) < $signed(b)) ? a : b;
         I_ANDN:  return a & ~b;
         default: return a ^ b ^ c ^ {55'd0, i};
      endcase
   endfunction

   assign u_rd_a = unit_model(u_insn_a, u_rs1_a, u_rs2_a, u_rs3_a);
   assign u_rd_f = unit_model(u_insn_f, u_rs1_f, u_rs2_f, u_rs3_f);

   rvb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b0)) dut_a (
      .clock(clk), .reset(rst),
      .req0_valid(req_valid[0]), .req0_ready(req_ready_a[0]),
      .req0_rs1(rs1[0]), .req0_rs2(rs2[0]), .req0_rs3(rs3[0]), .req0_insn(insn[0]),
      .req1_valid(req_valid[1]), .req1_ready(req_ready_a[1]),
      .req1_rs1(rs1[1]), .req1_rs2(rs2[1]), .req1_rs3(rs3[1]), .req1_insn(insn[1]),
      .rsp0_valid(rsp_valid_a[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rd(rsp_rd_a[0]),
      .rsp1_valid(rsp_valid_a[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rd(rsp_rd_a[1]),
      .unit_valid(unit_valid_a), .unit_rs1(u_rs1_a), .unit_rs2(u_rs2_a), .unit_rs3(u_rs3_a),
      .unit_insn(u_insn_a), .unit_rd(u_rd_a)
   );

   rvb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b1)) dut_f (
      .clock(clk), .reset(rst),
      .req0_valid(req_valid[0]), .req0_ready(req_ready_f[0]),
      .req0_rs1(rs1[0]), .req0_rs2(rs2[0]), .req0_rs3(rs3[0]), .req0_insn(insn[0]),
      .req1_valid(req_valid[1]), .req1_ready(req_ready_f[1]),
      .req1_rs1(rs1[1]), .req1_rs2(rs2[1]), .req1_rs3(rs3[1]), .req1_insn(insn[1]),
      .rsp0_valid(rsp_valid_f[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rd(rsp_rd_f[0]),
      .rsp1_valid(rsp_valid_f[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rd(rsp_rd_f[1]),
      .unit_valid(unit_valid_f), .unit_rs1(u_rs1_f), .unit_rs2(u_rs2_f), .unit_rs3(u_rs3_f),
      .unit_insn(u_insn_f), .unit_rd(u_rd_f)
   );

   task automatic set_req(input int i, input logic v, input logic [8:0] ins,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
      req_valid[i] = v;
      insn[i]      = ins;
      rs1[i]       = a;
      rs2[i]       = b;
      rs3[i]       = c;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      sb0.delete();
      sb1.delete();
      sbf0.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      #3;
      n_cmp++; if (rsp_valid_a !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_a); end
      n_cmp++; if (rsp_rd_a[0] !== '0) begin n_err++; $display("FAIL reset_rsp0_rd: got %h want 0", rsp_rd_a[0]); end
      n_cmp++; if (rsp_rd_a[1] !== '0) begin n_err++; $display("FAIL reset_rsp1_rd: got %h want 0", rsp_rd_a[1]); end
      n_cmp++; if (unit_valid_a !== 1'b0 || u_insn_a !== 9'd0 || u_rs1_a !== '0)
         begin n_err++; $display("FAIL reset_unit: got v=%b insn=%h rs1=%h want 0", unit_valid_a, u_insn_a, u_rs1_a); end
      n_cmp++; if (req_ready_a !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready_a); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready = 2'b01;
      set_req(0, 1'b1, I_MIN, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0);
      sb0.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      #2;
      n_cmp++; if (req_ready_a !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready_a); end
      n_cmp++; if (unit_valid_a !== 1'b1 || u_insn_a !== I_MIN || u_rs1_a !== 64'd5)
         begin n_err++; $display("FAIL single_unit: got v=%b insn=%h rs1=%h want 1/%h/5", unit_valid_a, u_insn_a, u_rs1_a, I_MIN); end
      n_cmp++; if (rsp_valid_a !== 2'b00) begin n_err++; $display("FAIL single_early_rsp: got %b want 00", rsp_valid_a); end
      next_cycle();
      req_valid = 2'b00;
      #2;
      n_cmp++; if (rsp_valid_a !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid_a); end
      exp_v = sb0.pop_front();
      n_cmp++; if (rsp_rd_a[0] !== exp_v) begin n_err++; $display("FAIL single_rsp_rd: got %h want %h", rsp_rd_a[0], exp_v); end
      next_cycle();
      #2;
      n_cmp++; if (rsp_valid_a !== 2'b00) begin n_err++; $display("FAIL single_drained: got %b want 00", rsp_valid_a); end
   endtask

   task automatic test_contention();
      int exp_g [4] = '{0, 1, 0, 1};
      do_reset();
      rsp_ready = 2'b11;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            set_req(0, 1'b1, 9'(9'h040 + k), 64'(64'h100 + k), 64'(64'h200 + k), 64'(64'h300 + k));
            set_req(1, 1'b1, 9'(9'h0C0 + k), 64'(64'h1000 + k), 64'(64'h2000 + k), 64'(64'h3000 + k));
            if (exp_g[k] == 0) sb0.push_back(unit_model(insn[0], rs1[0], rs2[0], rs3[0]));
            else               sb1.push_back(unit_model(insn[1], rs1[1], rs2[1], rs3[1]));
         end else begin
            req_valid = 2'b00;
         end
         #2;
         if (k < 4) begin
            n_cmp++; if (req_ready_a !== ((exp_g[k] == 0) ? 2'b01 : 2'b10))
               begin n_err++; $display("FAIL rr_grant[%0d]: got ready=%b want requester %0d", k, req_ready_a, exp_g[k]); end
            n_cmp++; if (u_insn_a !== insn[exp_g[k]])
               begin n_err++; $display("FAIL rr_unit_insn[%0d]: got %h want %h", k, u_insn_a, insn[exp_g[k]]); end
         end
         if (rsp_valid_a[0] && rsp_ready[0]) begin
            n_cmp++;
            if (sb0.size() == 0) begin n_err++; $display("FAIL rr_rsp0_extra: got %h want none", rsp_rd_a[0]); end
            else begin exp_v = sb0.pop_front(); if (rsp_rd_a[0] !== exp_v) begin n_err++; $display("FAIL rr_rsp0_rd: got %h want %h", rsp_rd_a[0], exp_v); end end
         end
         if (rsp_valid_a[1] && rsp_ready[1]) begin
            n_cmp++;
            if (sb1.size() == 0) begin n_err++; $display("FAIL rr_rsp1_extra: got %h want none", rsp_rd_a[1]); end
            else begin exp_v = sb1.pop_front(); if (rsp_rd_a[1] !== exp_v) begin n_err++; $display("FAIL rr_rsp1_rd: got %h want %h", rsp_rd_a[1], exp_v); end end
         end
         next_cycle();
      end
      n_cmp++; if (sb0.size() + sb1.size() != 0) begin n_err++; $display("FAIL rr_left: got %0d outstanding want 0", sb0.size() + sb1.size()); end
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 2'b11;
      for (int k = 0; k < 7; k++) begin
         rsp_ready[1] = (k < 2 || k == 6);
         if (k < 6) begin
            set_req(0, 1'b1, 9'(9'h011 + k), 64'(64'hA00 + k), 64'(64'hB00 + k), 64'd7);
            set_req(1, 1'b1, 9'(9'h091 + k), 64'(64'hC00 + k), 64'(64'hD00 + k), 64'd9);
            if (k == 1) sb1.push_back(unit_model(insn[1], rs1[1], rs2[1], rs3[1]));
            else        sb0.push_back(unit_model(insn[0], rs1[0], rs2[0], rs3[0]));
         end else begin
            req_valid = 2'b00;
         end
         #2;
         if (k < 6) begin
            n_cmp++; if (req_ready_a !== ((k == 1) ? 2'b10 : 2'b01))
               begin n_err++; $display("FAIL bp_grant[%0d]: got %b want %b", k, req_ready_a, (k == 1) ? 2'b10 : 2'b01); end
         end
         if (k >= 2) begin
            n_cmp++; if (rsp_valid_a[1] !== 1'b1 || sb1.size() == 0 || rsp_rd_a[1] !== sb1[0])
               begin n_err++; $display("FAIL bp_rsp1_hold[%0d]: got v=%b rd=%h want held first result", k, rsp_valid_a[1], rsp_rd_a[1]); end
         end
         if (rsp_valid_a[0] && rsp_ready[0]) begin
            n_cmp++;
            if (sb0.size() == 0) begin n_err++; $display("FAIL bp_rsp0_extra: got %h want none", rsp_rd_a[0]); end
            else begin exp_v = sb0.pop_front(); if (rsp_rd_a[0] !== exp_v) begin n_err++; $display("FAIL bp_rsp0_rd: got %h want %h", rsp_rd_a[0], exp_v); end end
         end
         if (rsp_valid_a[1] && rsp_ready[1]) begin
            n_cmp++;
            if (sb1.size() == 0) begin n_err++; $display("FAIL bp_rsp1_extra: got %h want none", rsp_rd_a[1]); end
            else begin exp_v = sb1.pop_front(); if (rsp_rd_a[1] !== exp_v) begin n_err++; $display("FAIL bp_rsp1_rd: got %h want %h", rsp_rd_a[1], exp_v); end end
         end
         next_cycle();
      end
      #2;
      n_cmp++; if (sb0.size() + sb1.size() != 0 || rsp_valid_a !== 2'b00)
         begin n_err++; $display("FAIL bp_left: got %0d outstanding valid=%b want 0/00", sb0.size() + sb1.size(), rsp_valid_a); end
   endtask

   task automatic test_drain_refill();
      do_reset();
      rsp_ready = 2'b01;
      set_req(0, 1'b1, I_ANDN, 64'hFF, 64'h0F, 64'd0);
      sb0.push_back(64'hF0);
      next_cycle();
      set_req(0, 1'b1, I_ANDN, 64'hF0, 64'h30, 64'd0);
      #2;
      n_cmp++; if (rsp_valid_a[0] !== 1'b1 || req_ready_a[0] !== 1'b1)
         begin n_err++; $display("FAIL dr_refill: got v=%b ready=%b want 1/1", rsp_valid_a[0], req_ready_a[0]); end
      exp_v = sb0.pop_front();
      n_cmp++; if (rsp_rd_a[0] !== exp_v) begin n_err++; $display("FAIL dr_first_rd: got %h want %h", rsp_rd_a[0], exp_v); end
      sb0.push_back(64'hC0);
      next_cycle();
      req_valid = 2'b00;
      #2;
      exp_v = sb0.pop_front();
      n_cmp++; if (rsp_valid_a[0] !== 1'b1 || rsp_rd_a[0] !== exp_v)
         begin n_err++; $display("FAIL dr_second_rd: got v=%b rd=%h want 1/%h", rsp_valid_a[0], rsp_rd_a[0], exp_v); end
      next_cycle();
      #2;
      n_cmp++; if (rsp_valid_a[0] !== 1'b0) begin n_err++; $display("FAIL dr_empty: got %b want 0", rsp_valid_a[0]); end
   endtask

   task automatic test_fixed_prio();
      do_reset();
      rsp_ready = 2'b01;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            set_req(0, 1'b1, 9'(9'h021 + k), 64'(64'h50 + k), 64'(64'h60 + k), 64'd1);
            set_req(1, 1'b1, 9'(9'h0A1 + k), 64'(64'h70 + k), 64'(64'h80 + k), 64'd2);
            sbf0.push_back(unit_model(insn[0], rs1[0], rs2[0], rs3[0]));
         end else begin
            req_valid = 2'b00;
         end
         #2;
         if (k < 3) begin
            n_cmp++; if (req_ready_f !== 2'b01 || u_insn_f !== insn[0])
               begin n_err++; $display("FAIL fp_grant[%0d]: got ready=%b insn=%h want 01/%h", k, req_ready_f, u_insn_f, insn[0]); end
         end
         if (rsp_valid_f[0] && rsp_ready[0]) begin
            n_cmp++;
            if (sbf0.size() == 0) begin n_err++; $display("FAIL fp_rsp0_extra: got %h want none", rsp_rd_f[0]); end
            else begin exp_v = sbf0.pop_front(); if (rsp_rd_f[0] !== exp_v) begin n_err++; $display("FAIL fp_rsp0_rd: got %h want %h", rsp_rd_f[0], exp_v); end end
         end
         next_cycle();
      end
      n_cmp++; if (sbf0.size() != 0) begin n_err++; $display("FAIL fp_left: got %0d outstanding want 0", sbf0.size()); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_req(1, 1'b1, 9'h033, 64'h1, 64'h2, 64'h3);
      #2;
      n_cmp++; if (req_ready_a !== 2'b10) begin n_err++; $display("FAIL ar_grant1: got %b want 10", req_ready_a); end
      next_cycle();
      req_valid = 2'b00;
      set_req(0, 1'b1, 9'h034, 64'h4, 64'h5, 64'h6);
      #2;
      n_cmp++; if (req_ready_a !== 2'b01) begin n_err++; $display("FAIL ar_grant0: got %b want 01", req_ready_a); end
      next_cycle();
      req_valid = 2'b00;
      #2;
      n_cmp++; if (rsp_valid_a !== 2'b11) begin n_err++; $display("FAIL ar_full: got %b want 11", rsp_valid_a); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (rsp_valid_a !== 2'b00 || rsp_rd_a[0] !== '0 || rsp_rd_a[1] !== '0)
         begin n_err++; $display("FAIL ar_async: got v=%b rd0=%h rd1=%h want 00/0/0", rsp_valid_a, rsp_rd_a[0], rsp_rd_a[1]); end
      next_cycle();
      rst = 1'b0;
      rsp_ready = 2'b11;
      set_req(0, 1'b1, 9'h035, 64'h7, 64'h8, 64'h9);
      set_req(1, 1'b1, 9'h036, 64'hA, 64'hB, 64'hC);
      #2;
      n_cmp++; if (req_ready_a !== 2'b01) begin n_err++; $display("FAIL ar_first_after: got %b want 01", req_ready_a); end
      next_cycle();
      #2;
      n_cmp++; if (req_ready_a !== 2'b10) begin n_err++; $display("FAIL ar_second_after: got %b want 10", req_ready_a); end
      next_cycle();
      req_valid = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         rs1[i] = '0; rs2[i] = '0; rs3[i] = '0; insn[i] = '0;
      end
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_drain_refill();
      test_fixed_prio();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rvb_arbiter.md
Name: rvb_arbiter

Overview:
- Two-requester front-end sharing one combinational bitmanip unit (the XLEN-wide B-extension datapath).
- Each requester has a valid/ready issue channel and a valid/ready response channel.
- Block picks at most one request per cycle (round-robin or fixed priority), drives the shared unit, and captures the same-cycle result into a one-entry response buffer for that requester.
- Sits between the two issue slots (or harts) and the shared unit. Unit input handshake is tied ready; the unit is purely combinational.

Parameters:
- XLEN, 64, operand/result width (32 or 64).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- clock  in  1  positive-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_rs1, req0_rs2, req0_rs3  in  XLEN each  requester 0 operands
- req0_insn  in  9  instruction bits {30,27,26,25,14,13,12,5,3}
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_rs3, req1_insn  as above, for requester 1
- rsp0_valid  out  1  requester 0 result valid
- rsp0_ready  in  1  requester 0 consumer accepts result
- rsp0_rd  out  XLEN  requester 0 result
- rsp1_valid, rsp1_ready, rsp1_rd  as above, for requester 1
- unit_valid  out  1  shared unit operation valid
- unit_rs1, unit_rs2, unit_rs3  out  XLEN each  shared unit operands
- unit_insn  out  9  shared unit instruction bits (same order as reqN_insn)
- unit_rd  in  XLEN  shared unit result, same cycle

Behaviour:
- Reset (async assert, synchronous release effect): rsp0_valid = rsp1_valid = 0; rsp0_rd = rsp1_rd = 0; prio = 0. Combinational outputs follow from these values.
- Eligibility: elig_i = reqi_valid && (!full_i || rspi_ready). A full buffer draining this cycle may be refilled in the same cycle.
- Grant, both eligible:
  - FIXED_PRIO = 1: grant 0.
  - FIXED_PRIO = 0: grant the requester indexed by prio.
- Grant, one eligible: grant it. None eligible: no grant.
- reqi_ready = grant_i. This is combinational and may depend on reqi_valid. At most one ready is high per cycle.
- prio update: on grant to i, prio <= ~i. With no grant, prio holds. prio is unused when FIXED_PRIO = 1.
- Unit drive:
  - unit_valid = grant_0 || grant_1.
  - unit_rs1/rs2/rs3/insn are muxed from the granted requester.
  - When there is no grant, all unit outputs are 0.
- Capture: on grant_i at the clock edge, rspi_rd <= unit_rd and full_i <= 1.
- Drain: rspi_valid && rspi_ready with no grant_i gives full_i <= 0. rspi_rd holds its last value.
- Simultaneous drain and refill: full_i stays 1 and rspi_rd takes the new result.
- Latency: accept at cycle N, rspi_valid high at N+1.
  - Aggregate throughput: 1 op/cycle.
  - Per-requester throughput: 1 op/cycle while its consumer holds rspi_ready = 1.
- Ordering: per-requester results return in acceptance order (one-entry buffer, so trivially).
- Fairness (round-robin): with both requesters continuously eligible, grants alternate strictly. No requester waits more than 1 cycle behind the other.
- Backpressure isolation: a stalled rsp1 consumer (full_1 && !rsp1_ready) must never block requester 0.
- rspi_valid and rspi_rd stay stable while rspi_valid && !rspi_ready.
- Reset mid-operation: buffered results are discarded and rsp valids drop immediately (async). No replay.

Test Plan:
- Single op: req0 MIN (insn 9'b010110010), rs1 = 5, rs2 = 64'hFFFF_FFFF_FFFF_FFFD, unit model in loop, rsp0_ready = 1 -> req0_ready = 1 at N; rsp0_valid = 1 at N+1 with rsp0_rd = 64'hFFFF_FFFF_FFFF_FFFD.
- Contention, round-robin, both valid for 4 cycles from reset -> grant order 0, 1, 0, 1; unit_insn mirrors the granted requester each cycle.
- Backpressure: rsp1_ready = 0 after the first req1 result, both requesters valid -> req1_ready stays 0; req0 is granted every cycle; rsp1_rd is held stable.
- Drain+refill: full_0 = 1, rsp0_ready = 1, req0_valid = 1 with ANDN (insn 9'b100011110), rs1 = 64'hF0, rs2 = 64'h30 -> rsp0_valid stays 1 and next rsp0_rd = 64'hC0.
- FIXED_PRIO = 1, both valid 3 cycles, rsp0_ready = 1 -> grants 0, 0, 0; req1_ready = 0 throughout.
- Async reset asserted mid-cycle with full_0 = full_1 = 1 -> rsp0_valid = rsp1_valid = 0 immediately, rsp*_rd = 0; after release the first grant goes to requester 0 when both are valid.
